tnn_popcount_accum: RTL

Sequential, parametrised ternary-neuron popcount accumulator for the TNN datapath. It accepts a weighted input vector as a stream of CHUNK_W-bit beats, each beat carrying positive-match and negative-match masks. Per beat it computes an exact or LSB-truncated popcount difference and accumulates it across beats. At the end of the vector it emits the signed sum and a ternary activation from two thresholds. It replaces the fixed 14-input combinational approximate popcount cores wherever neuron fan-in exceeds one chunk or the approximation level must be selectable at run time.

---
 rtl/tnn_pkg.sv | 25 ++
 rtl/tnn_popcount_chunk.sv | 33 +++
 rtl/tnn_popcount_accum.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// ---------------------------------------------------------------------------
// tnn_pkg
// Shared definitions for the ternary-neuron popcount accumulator:
//   - trit encodings driven on out_trit
//   - FSM state encoding of the accumulator
//   - acc_width(): signed accumulator width that covers +/- chunk_w*max_beats
// ---------------------------------------------------------------------------
package tnn_pkg;

  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ACC   = 2'd0,  // accepting beats
    DRAIN = 2'd1,  // folding the final staged beat into acc
    OUT   = 2'd2   // presenting the result
  } state_t;

  // One extra bit on top of the magnitude width provides the sign.
  function automatic int acc_width(input int chunk_w, input int max_beats);
    return $clog2(chunk_w * max_beats + 1) + 1;
  endfunction

endpackage

// File: rtl/tnn_popcount_chunk.sv
// ---------------------------------------------------------------------------
// tnn_popcount_chunk
// Combinational popcount of one CHUNK_W-bit mask with optional LSB truncation.
// Ports:
//   mask       in   CHUNK_W  bits to count
//   approx_en  in   1        clear the DROP low-order bits of the count
//   pc         out  PC_W     (possibly truncated) popcount
// ---------------------------------------------------------------------------
module tnn_popcount_chunk #(
  parameter  int CHUNK_W = 14,
  parameter  int DROP    = 1,
  localparam int PC_W    = $clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] mask,
  input  logic               approx_en,
  output logic [PC_W-1:0]    pc
);

  // Truncation is a mask rather than a shift pair: same result, no shifter.
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'((1 << DROP) - 1);

  logic [PC_W-1:0] pc_exact;

  always_comb begin
    pc_exact = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pc_exact = pc_exact + PC_W'(mask[i]);
    end
  end

  assign pc = approx_en ? (pc_exact & ~LOW_MASK) : pc_exact;

endmodule

// File: rtl/tnn_popcount_accum.sv
// ---------------------------------------------------------------------------
// tnn_popcount_accum
// Streams a ternary-weighted input vector as CHUNK_W-bit beats, accumulates
// popcount(pos) - popcount(neg) per beat (exact or LSB-truncated), and emits
// the signed sum plus a ternary activation from two thresholds.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   approx_en            truncated chunk popcounts, sampled per accepted beat
//   in_valid/in_ready    beat handshake
//   in_pos, in_neg       positive / negative match masks
//   in_last              final beat of the vector
//   thr_hi, thr_lo       activation thresholds, sampled on the final beat
//   out_valid/out_ready  result handshake
//   out_sum              accumulated signed sum
//   out_trit             activation (01 = +1, 00 = 0, 11 = -1)
//   out_trunc            vector was cut off at MAX_BEATS without in_last
// ---------------------------------------------------------------------------
module tnn_popcount_accum
  import tnn_pkg::*;
#(
  parameter  int CHUNK_W   = 14,
  parameter  int MAX_BEATS = 8,
  parameter  int DROP      = 1,
  localparam int ACC_W     = acc_width(CHUNK_W, MAX_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    approx_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK_W-1:0]      in_pos,
  input  logic [CHUNK_W-1:0]      in_neg,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [1:0]              out_trit,
  output logic                    out_trunc
);

  localparam int PC_W  = $clog2(CHUNK_W + 1);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_t                  state_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic signed [ACC_W-1:0] out_sum_reg;
  logic [1:0]              out_trit_reg;
  logic                    out_trunc_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] s1_reg;
  logic                    s1_vld_reg;
  logic [CNT_W-1:0]        beat_cnt_reg;
  logic signed [ACC_W-1:0] thr_hi_reg;
  logic signed [ACC_W-1:0] thr_lo_reg;

  logic [PC_W-1:0]         pc_pos;
  logic [PC_W-1:0]         pc_neg;
  logic signed [ACC_W-1:0] beat_d;
  logic                    beat_fire;
  logic                    end_beat;
  logic [1:0]              trit_next;

  tnn_popcount_chunk #(.CHUNK_W(CHUNK_W), .DROP(DROP)) u_pc_pos (
    .mask      (in_pos),
    .approx_en (approx_en),
    .pc        (pc_pos)
  );

  tnn_popcount_chunk #(.CHUNK_W(CHUNK_W), .DROP(DROP)) u_pc_neg (
    .mask      (in_neg),
    .approx_en (approx_en),
    .pc        (pc_neg)
  );

  // Zero-extended subtraction at full width yields the correct two's
  // complement difference because ACC_W exceeds PC_W.
  assign beat_d    = ACC_W'(pc_pos) - ACC_W'(pc_neg);
  assign beat_fire = in_valid && in_ready_reg && (state_reg == ACC);
  // The MAX_BEATS-th beat closes the vector whether or not in_last is set.
  assign end_beat  = in_last || (beat_cnt_reg == LAST_CNT);

  // +1 is tested first so it wins when the thresholds overlap.
  always_comb begin
    trit_next = TRIT_ZERO;
    if (acc_reg >= thr_hi_reg) begin
      trit_next = TRIT_POS;
    end else if (acc_reg <= thr_lo_reg) begin
      trit_next = TRIT_NEG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ACC;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_trit_reg  <= TRIT_ZERO;
      out_trunc_reg <= 1'b0;
      acc_reg       <= '0;
      s1_reg        <= '0;
      s1_vld_reg    <= 1'b0;
      beat_cnt_reg  <= '0;
      thr_hi_reg    <= '0;
      thr_lo_reg    <= '0;
    end else begin
      case (state_reg)
        ACC: begin
          // One-stage pipeline: the beat staged last cycle lands in acc now.
          if (s1_vld_reg) begin
            acc_reg <= acc_reg + s1_reg;
          end
          in_ready_reg <= 1'b1;
          if (beat_fire) begin
            s1_reg       <= beat_d;
            s1_vld_reg   <= 1'b1;
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (end_beat) begin
              thr_hi_reg    <= thr_hi;
              thr_lo_reg    <= thr_lo;
              out_trunc_reg <= !in_last;
              in_ready_reg  <= 1'b0;
              state_reg     <= DRAIN;
            end
          end else begin
            s1_vld_reg <= 1'b0;
          end
        end

        DRAIN: begin
          acc_reg    <= acc_reg + s1_reg;
          s1_vld_reg <= 1'b0;
          state_reg  <= OUT;
        end

        OUT: begin
          // First OUT cycle registers the result from the settled acc;
          // afterwards it is held until the consumer takes it.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_sum_reg   <= acc_reg;
            out_trit_reg  <= trit_next;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            acc_reg       <= '0;
            s1_reg        <= '0;
            beat_cnt_reg  <= '0;
            state_reg     <= ACC;
          end
        end

        default: begin
          state_reg    <= ACC;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_trit  = out_trit_reg;
  assign out_trunc = out_trunc_reg;

endmodule
